// File: rtl/instr_decode.sv
// instr_decode: IF/ID pipeline register that decodes 16-bit instruction words.
// Load-use bubble insertion is compiled in only when DECODE_HAZARD_EN is defined.
module instr_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [15:0] imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic        halt,
  output logic        illegal
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_BEQ  = 4'h9,
    OP_JMP  = 4'hA,
    OP_HLT  = 4'hF
  } opcode_e;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        halt;
    logic        illegal;
  } dec_t;

  dec_t dec_in;
  dec_t dec_d, dec_q;
  logic out_valid_d, out_valid_q;
  logic halted_d, halted_q;
  logic hazard;
  logic in_xfer, out_xfer;

  logic [15:0] sext4;
  assign sext4 = {{12{in_instr[3]}}, in_instr[3:0]};

  always_comb begin
    dec_in        = '0;
    dec_in.opcode = in_instr[15:12];
    case (in_instr[15:12])
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        dec_in.rd        = in_instr[11:8];
        dec_in.rs1       = in_instr[7:4];
        dec_in.rs2       = in_instr[3:0];
        dec_in.reg_write = 1'b1;
      end
      OP_ADDI, OP_LD: begin
        dec_in.rd        = in_instr[11:8];
        dec_in.rs1       = in_instr[7:4];
        dec_in.imm       = sext4;
        dec_in.reg_write = 1'b1;
        dec_in.mem_read  = (in_instr[15:12] == OP_LD);
      end
      OP_ST: begin
        dec_in.rs2       = in_instr[11:8];
        dec_in.rs1       = in_instr[7:4];
        dec_in.imm       = sext4;
        dec_in.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_in.rs1    = in_instr[11:8];
        dec_in.rs2    = in_instr[7:4];
        dec_in.imm    = sext4;
        dec_in.branch = 1'b1;
      end
      OP_JMP: begin
        dec_in.imm  = {{4{in_instr[11]}}, in_instr[11:0]};
        dec_in.jump = 1'b1;
      end
      OP_HLT:  dec_in.halt    = 1'b1;
      default: dec_in.illegal = 1'b1;
    endcase
  end

`ifdef DECODE_HAZARD_EN
  // Only sources the incoming format actually reads may raise a hazard;
  // normalized-to-zero fields must not alias a held rd of 0.
  logic use_rs1, use_rs2;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (in_instr[15:12])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ST, OP_BEQ: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_ADDI, OP_LD: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign hazard = out_valid_q & dec_q.mem_read & in_valid &
                  ((use_rs1 & (dec_in.rs1 == dec_q.rd)) |
                   (use_rs2 & (dec_in.rs2 == dec_q.rd)));
`else
  assign hazard = 1'b0;
`endif

  assign in_ready = (~out_valid_q | out_ready) & ~halted_q & ~hazard & ~flush;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    dec_d       = dec_q;
    out_valid_d = out_valid_q;
    halted_d    = halted_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_xfer) begin
      dec_d       = dec_in;
      out_valid_d = 1'b1;
      if (dec_in.halt) halted_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_q       <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = dec_q.opcode;
  assign rd        = dec_q.rd;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign imm       = dec_q.imm;
  assign reg_write = dec_q.reg_write;
  assign mem_read  = dec_q.mem_read;
  assign mem_write = dec_q.mem_write;
  assign branch    = dec_q.branch;
  assign jump      = dec_q.jump;
  assign halt      = dec_q.halt;
  assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode; expectations follow DECODE_HAZARD_EN.
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode, rd, rs1, rs2;
  logic [15:0] imm;
  logic        reg_write, mem_read, mem_write, branch, jump, halt, illegal;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [38:0] sb[$];
  logic [38:0] obs;
  logic [38:0] exp_v;

  always #5 clk = ~clk;

  assign obs = {opcode, rd, rs1, rs2, imm,
                reg_write, mem_read, mem_write, branch, jump, halt, illegal};

  instr_decode dut (
    .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .halt(halt),
    .illegal(illegal)
  );

  // Reference decode; flags ordered {rw, mr, mw, br, jp, ht, il}.
  function automatic logic [38:0] model(input logic [15:0] w);
    logic [3:0]  op, a, b, c, rd_e, rs1_e, rs2_e;
    logic [15:0] imm_e, s4;
    logic [6:0]  f;
    op = w[15:12]; a = w[11:8]; b = w[7:4]; c = w[3:0];
    s4 = {{12{c[3]}}, c};
    rd_e = 4'h0; rs1_e = 4'h0; rs2_e = 4'h0; imm_e = 16'h0; f = 7'b0;
    if (op >= 4'h1 && op <= 4'h5) begin
      rd_e = a; rs1_e = b; rs2_e = c; f = 7'b1000000;
    end else if (op == 4'h6) begin
      rd_e = a; rs1_e = b; imm_e = s4; f = 7'b1000000;
    end else if (op == 4'h7) begin
      rd_e = a; rs1_e = b; imm_e = s4; f = 7'b1100000;
    end else if (op == 4'h8) begin
      rs2_e = a; rs1_e = b; imm_e = s4; f = 7'b0010000;
    end else if (op == 4'h9) begin
      rs1_e = a; rs2_e = b; imm_e = s4; f = 7'b0001000;
    end else if (op == 4'hA) begin
      imm_e = {{4{w[11]}}, w[11:0]}; f = 7'b0000100;
    end else if (op == 4'hF) begin
      f = 7'b0000010;
    end else if (op != 4'h0) begin
      f = 7'b0000001;
    end
    return {op, rd_e, rs1_e, rs2_e, imm_e, f};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_instr = 16'h0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (obs !== 39'h0) begin errors++; $display("FAIL reset_outputs got %h want 0", obs); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    int unsigned idx, cyc;
    bit prev_acc;
    words = '{16'h1123, 16'h6215, 16'hA7FF};
    idx = 0; cyc = 0; prev_acc = 1'b0;
    out_ready = 1'b1;
    while ((idx < 3 || sb.size() != 0) && cyc < 20) begin
      in_valid = (idx < 3);
      if (idx < 3) in_instr = words[idx];
      @(negedge clk);
      if (prev_acc) begin
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_latency got out_valid=%b want 1", out_valid); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL b2b_spurious got %h want no output", obs); end
        else begin
          exp_v = sb.pop_front();
          if (obs !== exp_v) begin errors++; $display("FAIL b2b_decode got %h want %h", obs, exp_v); end
        end
      end
      prev_acc = in_valid && in_ready;
      if (prev_acc) begin sb.push_back(model(in_instr)); idx++; end
      next_cycle();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 3 || sb.size() != 0) begin
      errors++; $display("FAIL b2b_timeout got sent=%0d pending=%0d want 3/0", idx, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_load_use();
    logic [15:0] words [2];
    logic [4:0]  ov, ov_exp;
    logic        rdy1, rdy1_exp;
    int unsigned idx;
    words = '{16'h7310, 16'h1435};
    idx = 0; ov = '0; rdy1 = 1'b0;
`ifdef DECODE_HAZARD_EN
    ov_exp = 5'b01010; rdy1_exp = 1'b0;
`else
    ov_exp = 5'b00110; rdy1_exp = 1'b1;
`endif
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = (idx < 2);
      if (idx < 2) in_instr = words[idx];
      @(negedge clk);
      ov[cyc] = out_valid;
      if (cyc == 1) rdy1 = in_ready;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL lu_spurious got %h want no output", obs); end
        else begin
          exp_v = sb.pop_front();
          if (obs !== exp_v) begin errors++; $display("FAIL lu_decode got %h want %h", obs, exp_v); end
        end
      end
      if (in_valid && in_ready) begin sb.push_back(model(in_instr)); idx++; end
      next_cycle();
    end
    in_valid = 1'b0;
    checks++;
    if (ov !== ov_exp) begin errors++; $display("FAIL lu_pattern got %b want %b", ov, ov_exp); end
    checks++;
    if (rdy1 !== rdy1_exp) begin errors++; $display("FAIL lu_in_ready got %b want %b", rdy1, rdy1_exp); end
    checks++;
    if (sb.size() != 0 || idx != 2) begin
      errors++; $display("FAIL lu_drain got sent=%0d pending=%0d want 2/0", idx, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h8420;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got in_ready=%b want 1", in_ready); end
    if (in_valid && in_ready) sb.push_back(model(in_instr));
    next_cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
        errors++; $display("FAIL bp_hold got valid/ready=%b%b want 10", out_valid, in_ready);
      end
      checks++;
      if (sb.size() == 0 || obs !== sb[0]) begin
        errors++; $display("FAIL bp_stable got %h want %h", obs, model(16'h8420));
      end
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid && sb.size() != 0) begin
      exp_v = sb.pop_front();
      if (obs !== exp_v) begin errors++; $display("FAIL bp_release got %h want %h", obs, exp_v); end
    end else begin
      errors++; $display("FAIL bp_release got out_valid=%b want 1", out_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
    next_cycle();
    sb.delete();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h9120;
    @(negedge clk);
    if (in_valid && in_ready) sb.push_back(model(in_instr));
    next_cycle();
    flush = 1'b1; in_instr = 16'h2345;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    checks++;
    if (sb.size() == 0 || obs !== sb[0] || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_held got %h valid=%b want %h valid=1", obs, out_valid, model(16'h9120));
    end
    next_cycle();
    flush = 1'b0; in_valid = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_recover got %b want 1", in_ready); end
    next_cycle();
    sb.delete();
  endtask

  task automatic test_halt();
    logic [15:0] words [2];
    int unsigned idx;
    bit accepted_after;
    words = '{16'hF000, 16'h1111};
    idx = 0; accepted_after = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid = 1'b1;
      in_instr = (idx < 2) ? words[idx] : 16'h1111;
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL halt_spurious got %h want no output", obs); end
        else begin
          exp_v = sb.pop_front();
          if (obs !== exp_v) begin errors++; $display("FAIL halt_decode got %h want %h", obs, exp_v); end
        end
      end
      if (cyc >= 1 && in_ready) accepted_after = 1'b1;
      if (in_valid && in_ready) begin sb.push_back(model(in_instr)); idx++; end
      next_cycle();
    end
    checks++;
    if (accepted_after || idx != 1) begin
      errors++; $display("FAIL halt_block got accepted=%0d want 1", idx);
    end
    rst = 1'b0; in_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL halt_reset got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    next_cycle();
  endtask

  task automatic test_illegal_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'hC000;
    @(negedge clk);
    if (in_valid && in_ready) sb.push_back(model(in_instr));
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sb.size() == 0 || out_valid !== 1'b1 || obs !== sb[0]) begin
      errors++; $display("FAIL illegal_decode got %h valid=%b want %h valid=1", obs, out_valid, model(16'hC000));
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || obs !== 39'h0) begin
      errors++; $display("FAIL async_reset got %h valid=%b want 0 valid=0", obs, out_valid);
    end
    sb.delete();
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_backpressure();
    test_flush();
    test_halt();
    test_illegal_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
